vga_scan_ctrl: RTL and testbench



---
 rtl/vga_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: raster scan initiator for the 640x480@60 display path.
// Sweeps row/col addresses out to the pixel responders, takes back their
// registered colour PIX_LAT clocks later and re-aligns it with delayed sync.
//
// Ports:
//   clk        pixel clock (25 MHz)
//   N_rst      asynchronous active-low reset
//   pixel_data {R,G,B} from responders, PIX_LAT clocks after the address
//   row_addr   visible row of the current address (valid when rdn=0)
//   col_addr   visible column of the current address (valid when rdn=0)
//   rdn        active-low address valid
//   fresh      high during visible rows; falling edge = end of visible frame
//   hs, vs     active-low syncs, aligned with r/g/b
//   r, g, b    colour to DAC, black outside the visible area
//   frame_cnt  completed frames, wraps at 256
module vga_scan_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIX_LAT  = 1
) (
  input  logic        clk,
  input  logic        N_rst,
  input  logic [11:0] pixel_data,
  output logic [8:0]  row_addr,
  output logic [9:0]  col_addr,
  output logic        rdn,
  output logic        fresh,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_S  = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_E  = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_S  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_E  = VW'(V_SYNC + V_BP + V_ACTIVE);

  // scan counters
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [7:0]    frame_q, frame_d;
  logic          h_wrap, v_wrap, h_act, v_act;

  // address stage
  logic [8:0] row_q, row_d;
  logic [9:0] col_q, col_d;
  logic       rdn_q, rdn_d;
  logic       fresh_q, fresh_d;
  logic       hs_raw_q, hs_raw_d;
  logic       vs_raw_q, vs_raw_d;

  // delay line matching the responder latency
  logic [PIX_LAT-1:0] rdn_dly_q, rdn_dly_d;
  logic [PIX_LAT-1:0] hs_dly_q, hs_dly_d;
  logic [PIX_LAT-1:0] vs_dly_q, vs_dly_d;

  // colour stage
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    frame_d = frame_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
      // frame wrap coincides with the h and v wraps on the same edge
      if (v_wrap) frame_d = frame_q + 8'd1;
    end
  end

  always_comb begin
    h_act    = (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E);
    v_act    = (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);
    col_d    = 10'(h_cnt_q - H_ACT_S);
    row_d    = 9'(v_cnt_q - V_ACT_S);
    rdn_d    = ~(h_act & v_act);
    fresh_d  = v_act;
    hs_raw_d = (h_cnt_q >= H_SYNC_E);
    vs_raw_d = (v_cnt_q >= V_SYNC_E);
  end

  always_comb begin
    rdn_dly_d    = rdn_dly_q;
    hs_dly_d     = hs_dly_q;
    vs_dly_d     = vs_dly_q;
    rdn_dly_d[0] = rdn_q;
    hs_dly_d[0]  = hs_raw_q;
    vs_dly_d[0]  = vs_raw_q;
    for (int unsigned i = 1; i < PIX_LAT; i++) begin
      rdn_dly_d[i] = rdn_dly_q[i-1];
      hs_dly_d[i]  = hs_dly_q[i-1];
      vs_dly_d[i]  = vs_dly_q[i-1];
    end
    // blanking is decided from the delayed rdn, so responders may return
    // anything outside the visible area
    rgb_d = rdn_dly_q[PIX_LAT-1] ? '0 : pixel_data;
    hs_d  = hs_dly_q[PIX_LAT-1];
    vs_d  = vs_dly_q[PIX_LAT-1];
  end

  always_ff @(posedge clk or negedge N_rst) begin
    if (!N_rst) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      frame_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      rdn_q     <= 1'b1;
      fresh_q   <= 1'b0;
      hs_raw_q  <= 1'b1;
      vs_raw_q  <= 1'b1;
      rdn_dly_q <= '1;
      hs_dly_q  <= '1;
      vs_dly_q  <= '1;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      frame_q   <= frame_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rdn_q     <= rdn_d;
      fresh_q   <= fresh_d;
      hs_raw_q  <= hs_raw_d;
      vs_raw_q  <= vs_raw_d;
      rdn_dly_q <= rdn_dly_d;
      hs_dly_q  <= hs_dly_d;
      vs_dly_q  <= vs_dly_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign row_addr  = row_q;
  assign col_addr  = col_q;
  assign rdn       = rdn_q;
  assign fresh     = fresh_q;
  assign hs        = hs_q;
  assign vs        = vs_q;
  assign r         = rgb_q[11:8];
  assign g         = rgb_q[7:4];
  assign b         = rgb_q[3:0];
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: one full-size instance (d_*) for line timing,
// pixel alignment and async reset, plus two reduced-geometry instances
// (25x11 total, 16x6 visible) for whole-frame behaviour: s_* with PIX_LAT=1,
// l_* with PIX_LAT=3.
module tb_vga_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d, rst_s, white;

  logic [11:0] d_pix, s_pix, l_pix, l_p0, l_p1;
  logic [8:0]  d_row, s_row, l_row;
  logic [9:0]  d_col, s_col, l_col;
  logic        d_rdn, d_fresh, d_hs, d_vs;
  logic        s_rdn, s_fresh, s_hs, s_vs;
  logic        l_rdn, l_fresh, l_hs, l_vs;
  logic [3:0]  d_r, d_g, d_b, s_r, s_g, s_b, l_r, l_g, l_b;
  logic [7:0]  d_frame, s_frame, l_frame;

  vga_scan_ctrl dut (
    .clk(clk), .N_rst(rst_d), .pixel_data(d_pix),
    .row_addr(d_row), .col_addr(d_col), .rdn(d_rdn), .fresh(d_fresh),
    .hs(d_hs), .vs(d_vs), .r(d_r), .g(d_g), .b(d_b), .frame_cnt(d_frame)
  );

  vga_scan_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIX_LAT(1)
  ) dut_s (
    .clk(clk), .N_rst(rst_s), .pixel_data(s_pix),
    .row_addr(s_row), .col_addr(s_col), .rdn(s_rdn), .fresh(s_fresh),
    .hs(s_hs), .vs(s_vs), .r(s_r), .g(s_g), .b(s_b), .frame_cnt(s_frame)
  );

  vga_scan_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIX_LAT(3)
  ) dut_l (
    .clk(clk), .N_rst(rst_s), .pixel_data(l_pix),
    .row_addr(l_row), .col_addr(l_col), .rdn(l_rdn), .fresh(l_fresh),
    .hs(l_hs), .vs(l_vs), .r(l_r), .g(l_g), .b(l_b), .frame_cnt(l_frame)
  );

  // responder models: {col[3:0], row[3:0], 4'hA} after 1 (d, s) or 3 (l) clocks
  always @(posedge clk) begin
    d_pix <= white ? 12'hFFF : {d_col[3:0], d_row[3:0], 4'hA};
    s_pix <= {s_col[3:0], s_row[3:0], 4'hA};
    l_p0  <= {l_col[3:0], l_row[3:0], 4'hA};
    l_p1  <= l_p0;
    l_pix <= l_p1;
  end

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned e     = 0;   // clock edges since the last reset release

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv_to(input int unsigned t);
    while (e < t) begin
      @(negedge clk);
      e++;
    end
  endtask

  int unsigned rdn_cnt, first_e, last_e, hs_low, vs_low, hs_falls;
  int unsigned fresh_falls, fresh_e0, fresh_bad, lowc;
  int unsigned hs_fall_e [2];
  logic [8:0]  first_row, last_row;
  logic [9:0]  first_col, last_col;
  logic        hs_prev, fresh_prev;

  initial begin
    rst_d = 1'b0;
    rst_s = 1'b0;
    white = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("d_rst_hs", d_hs, 1);
    chk("d_rst_vs", d_vs, 1);
    chk("d_rst_rdn", d_rdn, 1);
    chk("d_rst_fresh", d_fresh, 0);
    chk("d_rst_rgb", {d_r, d_g, d_b}, 0);
    chk("d_rst_frame", d_frame, 0);
    chk("d_rst_addr", {d_row, d_col}, 0);
    chk("s_rst_hs", s_hs, 1);
    chk("l_rst_vs", l_vs, 1);

    // reduced geometry: three frames of free run
    rst_s = 1'b1;
    e = 0;
    rdn_cnt = 0; first_e = 0; last_e = 0; hs_low = 0; vs_low = 0;
    hs_falls = 0; fresh_falls = 0; fresh_e0 = 0; fresh_bad = 0;
    first_row = '0; first_col = '0; last_row = '0; last_col = '0;
    hs_fall_e[0] = 0; hs_fall_e[1] = 0;
    hs_prev = 1'b1; fresh_prev = 1'b0;
    for (int i = 0; i < 560; i++) begin
      @(negedge clk);
      e++;
      if (e <= 275 && !s_rdn) begin
        rdn_cnt++;
        if (first_e == 0) begin
          first_e = e; first_row = s_row; first_col = s_col;
        end
        last_e = e; last_row = s_row; last_col = s_col;
      end
      if (e >= 3 && e <= 277) begin
        if (!s_hs) hs_low++;
        if (!s_vs) vs_low++;
      end
      if (hs_prev && !s_hs) begin
        if (hs_falls < 2) hs_fall_e[hs_falls] = e;
        hs_falls++;
      end
      if (fresh_prev && !s_fresh) begin
        if (fresh_falls == 0) fresh_e0 = e;
        fresh_falls++;
        if (!s_rdn) fresh_bad++;
      end
      hs_prev = s_hs;
      fresh_prev = s_fresh;
      if (e == 109) chk("s_rgb_blank", {s_r, s_g, s_b}, 12'h000);
      if (e == 110) chk("s_rgb_r0c0", {s_r, s_g, s_b}, 12'h00A);
      if (e == 274) chk("s_frame_274", s_frame, 0);
      if (e == 275) chk("s_frame_275", s_frame, 1);
      if (e == 550) chk("s_frame_550", s_frame, 2);
      if (e == 4)   chk("l_hs_4", l_hs, 1);
      if (e == 5)   chk("l_hs_5", l_hs, 0);
      if (e == 8)   chk("l_hs_8", l_hs, 0);
      if (e == 9)   chk("l_hs_9", l_hs, 1);
      if (e == 111) chk("l_rgb_blank", {l_r, l_g, l_b}, 12'h000);
      if (e == 112) chk("l_rgb_r0c0", {l_r, l_g, l_b}, 12'h00A);
      if (e == 139) chk("l_rgb_r1c2", {l_r, l_g, l_b}, 12'h21A);
      if (e == 140) chk("l_rgb_r1c3", {l_r, l_g, l_b}, 12'h31A);
    end
    chk("s_rdn_cnt", rdn_cnt, 96);
    chk("s_first_e", first_e, 108);
    chk("s_first_addr", {first_row, first_col}, {9'd0, 10'd0});
    chk("s_last_e", last_e, 248);
    chk("s_last_addr", {last_row, last_col}, {9'd5, 10'd15});
    chk("s_hs_low", hs_low, 44);
    chk("s_vs_low", vs_low, 50);
    chk("s_hs_fall0", hs_fall_e[0], 3);
    chk("s_hs_fall1", hs_fall_e[1], 28);
    chk("s_fresh_falls", fresh_falls, 2);
    chk("s_fresh_fall_e", fresh_e0, 251);
    chk("s_fresh_rdn", fresh_bad, 0);

    // full-size instance
    rst_d = 1'b1;
    e = 0;
    adv_to(2);
    chk("d_hs_2", d_hs, 1);
    adv_to(3);
    chk("d_hs_3", d_hs, 0);
    chk("d_vs_3", d_vs, 0);
    lowc = 0;
    do begin
      if (!d_hs) lowc++;
      adv_to(e + 1);
    end while (e <= 802);
    chk("d_hs_low", lowc, 96);
    chk("d_hs_803", d_hs, 0);
    adv_to(1602);
    chk("d_vs_1602", d_vs, 0);
    adv_to(1603);
    chk("d_vs_1603", d_vs, 1);
    adv_to(1700);
    white = 1'b1;
    adv_to(1710);
    chk("d_white_vblank", {d_r, d_g, d_b}, 12'h000);
    white = 1'b0;
    adv_to(28000);
    chk("d_fresh_28000", d_fresh, 0);
    adv_to(28001);
    chk("d_fresh_28001", d_fresh, 1);
    adv_to(28144);
    chk("d_rdn_28144", d_rdn, 1);
    adv_to(28145);
    chk("d_rdn_28145", d_rdn, 0);
    chk("d_first_addr", {d_row, d_col}, {9'd0, 10'd0});
    adv_to(32163);
    chk("d_rgb_r5c16", {d_r, d_g, d_b}, 12'h05A);
    adv_to(32164);
    chk("d_rgb_r5c17", {d_r, d_g, d_b}, 12'h15A);
    chk("d_hs_vis", d_hs, 1);
    white = 1'b1;
    adv_to(32166);
    chk("d_white_vis", {d_r, d_g, d_b}, 12'hFFF);
    adv_to(32795);
    chk("d_white_hblank", {d_r, d_g, d_b}, 12'h000);
    white = 1'b0;

    // async reset mid-line at h_cnt=300, v_cnt=41
    adv_to(33100);
    chk("d_pre_rst_rdn", d_rdn, 0);
    chk("d_pre_rst_fresh", d_fresh, 1);
    #2 rst_d = 1'b0;
    #1;
    chk("d_arst_rdn", d_rdn, 1);
    chk("d_arst_fresh", d_fresh, 0);
    chk("d_arst_sync", {d_hs, d_vs}, 2'b11);
    chk("d_arst_rgb", {d_r, d_g, d_b}, 12'h000);
    chk("d_arst_addr", {d_row, d_col}, 0);
    chk("d_arst_frame", d_frame, 0);
    @(negedge clk);
    rst_d = 1'b1;
    e = 0;
    adv_to(2);
    chk("d_rel_hs_2", d_hs, 1);
    adv_to(3);
    chk("d_rel_hs_3", d_hs, 0);
    chk("d_rel_vs_3", d_vs, 0);
    chk("d_rel_rdn_3", d_rdn, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
